// File: rtl/beat_sequencer.sv
// Run/stop/single-step controller around a one-hot 4-beat ring (T1=1000 .. T4=0001).
// The final beat is chosen per instruction from beat_len; hold stalls the beat.
module beat_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             hold,
    input  logic [1:0]       beat_len,
    output logic [3:0]       T,
    output logic             instr_done,
    output logic             running,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] len_q;
    logic       stop_pending;
    logic [1:0] idx;
    logic       last;

    always_comb begin
        idx = 2'd0;
        case (T)
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            4'b0001: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // During T1 the live beat_len decides; afterwards the value latched at T1 does.
    assign last       = (T == 4'b1000) ? (beat_len == 2'd0) : (idx == len_q);
    assign instr_done = (state != IDLE) && last && !hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            T            <= 4'b0000;
            running      <= 1'b0;
            instr_cnt    <= '0;
            stop_pending <= 1'b0;
            len_q        <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    stop_pending <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        T       <= 4'b1000;
                        running <= 1'b1;
                    end else if (step) begin
                        state   <= STEP;
                        T       <= 4'b1000;
                        running <= 1'b1;
                    end
                end
                RUN, STEP: begin
                    if (T == 4'b1000)
                        len_q <= beat_len;
                    if (state == RUN && stop)
                        stop_pending <= 1'b1;
                    if (!hold) begin
                        if (last) begin
                            instr_cnt <= instr_cnt + 1'b1;
                            if (state == STEP || stop_pending || stop) begin
                                state        <= IDLE;
                                T            <= 4'b0000;
                                running      <= 1'b0;
                                stop_pending <= 1'b0;
                            end else begin
                                T <= 4'b1000;
                            end
                        end else begin
                            T <= T >> 1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    T       <= 4'b0000;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// Randomized and directed stimulus against an instruction-level model; a monitor checks every cycle.
module tb_beat_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          step = 1'b0;
    logic          hold = 1'b0;
    logic [1:0]    beat_len = 2'd0;
    logic [3:0]    T;
    logic          instr_done;
    logic          running;
    logic [CW-1:0] instr_cnt;

    always #5 clk = ~clk;

    beat_sequencer #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .hold       (hold),
        .beat_len   (beat_len),
        .T          (T),
        .instr_done (instr_done),
        .running    (running),
        .instr_cnt  (instr_cnt)
    );

    typedef struct packed {
        logic [3:0]    t;
        logic          done;
        logic          run;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle_no = 0;

    // Model: mode 0 idle, 1 run, 2 step; beat is the 0-based beat number in the instruction.
    int m_mode = 0;
    int m_beat = 0;
    int m_len  = 0;
    bit m_stop = 0;
    int m_cnt  = 0;

    function automatic bit m_last();
        if (m_beat == 0)
            return (beat_len == 2'd0);
        return (m_beat == m_len);
    endfunction

    task automatic cyc(input bit r, input bit s, input bit st, input bit h, input bit sp, input int bl);
        exp_t e;
        bit   fin;
        rst = r; start = s; step = st; hold = h; stop = sp; beat_len = bl[1:0];
        e.t    = (m_mode != 0) ? 4'(8 >> m_beat) : 4'b0000;
        e.done = (m_mode != 0) && m_last() && !h;
        e.run  = (m_mode != 0);
        e.cnt  = m_cnt[CW-1:0];
        q.push_back(e);
        fin = e.done;
        @(posedge clk);
        if (r) begin
            m_mode = 0; m_beat = 0; m_len = 0; m_stop = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            m_stop = 0;
            if (s) begin m_mode = 1; m_beat = 0; end
            else if (st) begin m_mode = 2; m_beat = 0; end
        end else begin
            if (m_beat == 0) m_len = bl;
            if (m_mode == 1 && sp) m_stop = 1;
            if (fin) begin
                m_cnt = (m_cnt + 1) % (1 << CW);
                if (m_mode == 2 || m_stop || sp) begin
                    m_mode = 0; m_stop = 0;
                end
                m_beat = 0;
            end else if (!h) begin
                m_beat = m_beat + 1;
            end
        end
        #1;
    endtask

    task automatic idle_cycles(input int n, input int bl);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, bl);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cycle_no++;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (T !== e.t || instr_done !== e.done || running !== e.run || instr_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got T=%b done=%b run=%b cnt=%0d, want T=%b done=%b run=%b cnt=%0d",
                             cycle_no, T, instr_done, running, instr_cnt, e.t, e.done, e.run, e.cnt);
                end
                checks++;
                if (!$onehot0(T)) begin
                    errors++;
                    $display("FAIL onehot cycle %0d: got T=%b, want one-hot or 0000", cycle_no, T);
                end
            end
        end
    end

    initial begin : stim
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 0, 0);
        // Continuous run, 4 beats per instruction, then stop.
        cyc(0, 1, 0, 0, 0, 3);
        idle_cycles(12, 3);
        cyc(0, 0, 0, 0, 1, 3);
        idle_cycles(4, 3);
        // Single step, 2 beats.
        cyc(0, 0, 1, 0, 0, 1);
        idle_cycles(3, 1);
        // Stop requested during T2.
        cyc(0, 1, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 1, 3);
        idle_cycles(4, 3);
        // Hold three cycles at T3, stop at T4.
        cyc(0, 1, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 0, 3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 3);
        cyc(0, 0, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 1, 3);
        idle_cycles(2, 3);
        // Lengths 1, 3, 2 with beat_len wiggled after T1.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 2);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 3);
        idle_cycles(2, 0);
        // Reset at T3.
        cyc(0, 1, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 0, 3);
        cyc(1, 0, 0, 0, 0, 3);
        idle_cycles(2, 3);
        // start and step together.
        cyc(0, 1, 1, 0, 0, 0);
        idle_cycles(20, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle_cycles(2, 0);
        // Random traffic; counter wraps many times at this width.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 29) == 0), int'($urandom_range(0, 3)));
        end
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Run/stop controller wrapped around the 4-phase beat ring (T1..T4, one-hot, T1 = 4'b1000 first, T4 = 4'b0001 last).
- Starts, stops and single-steps instruction execution.
- Shortens each instruction to 1..4 beats and supports wait-state stalls.
- Counts completed instructions; sits between the front-panel/debug controls and the multi-cycle datapath control logic.

Parameters:
CNT_W, 16, width of the completed-instruction counter.

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  reset, synchronous and active-high
start  in  1  begin continuous execution (level sampled each cycle)
stop  in  1  request halt at end of current instruction
step  in  1  execute exactly one instruction from idle
hold  in  1  stall: freeze current beat (memory wait)
beat_len  in  2  beats for current instruction minus 1 (0 = 1 beat .. 3 = 4 beats)
T  out  4  one-hot beat; 1000 = T1, 0100 = T2, 0010 = T3, 0001 = T4; 0000 when idle
instr_done  out  1  high during final beat of an instruction when hold = 0
running  out  1  high whenever state is not IDLE
instr_cnt  out  CNT_W  completed-instruction count

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, T = 0000, instr_done = 0, running = 0, instr_cnt = 0, stop_pending = 0, len_q = 0.
- Reset mid-instruction: reset values at the next edge; no instr_done pulse or count increment for the aborted instruction.
- States: IDLE, RUN, STEP.
- IDLE:
  - T = 0000.
  - start = 1 -> RUN, T = 1000 on the following cycle.
  - step = 1 and start = 0 -> STEP, T = 1000 on the following cycle.
  - start and step together -> RUN (start wins).
  - stop and hold are ignored.
- Beat advance (RUN/STEP), hold = 0: T shifts right one position per cycle (1000 -> 0100 -> 0010 -> 0001).
- Hold: hold = 1 freezes T and the beat index for that cycle; instr_done = 0; len_q reload still occurs if T = 1000.
- Length:
  - len_q loads beat_len on every cycle T = 1000.
  - During T1: last = (beat_len == 0).
  - During later beats: last = (beat index == len_q).
  - beat_len changes after T1 are ignored for the current instruction.
- instr_done is combinational: asserted in the same cycle as the final beat when hold = 0.
- After the final beat (hold = 0):
  - RUN with stop_pending = 0 and stop = 0: T = 1000 next cycle. Back-to-back instructions, no idle gap.
  - RUN with stop_pending = 1 or stop = 1 -> IDLE, T = 0000.
  - STEP: always -> IDLE.
- stop_pending:
  - Set by stop = 1 in any RUN cycle, including held cycles.
  - Cleared on entry to IDLE.
  - stop in STEP has no effect (STEP ends anyway).
- Ignored inputs: start in RUN/STEP; step in RUN/STEP.
- instr_cnt increments by 1 on each instr_done cycle; wraps modulo 2^CNT_W (all-ones -> 0).
- running is registered with state: 1 in RUN/STEP, 0 in IDLE.
- Invariant: T is always one-hot or 0000; never multi-hot.

Test Plan:
- Reset, then start pulse with beat_len = 3 -> T = 1000, 0100, 0010, 0001 repeating; instr_done high on each 0001; instr_cnt = 3 after 12 beats.
- step pulse with beat_len = 1 -> T = 1000, 0100, then 0000; one instr_done on 0100; running falls; instr_cnt = 1.
- RUN with beat_len = 3; stop pulsed during T2 -> instruction completes through 0001, then T = 0000, running = 0; no further T1.
- hold = 1 for 3 cycles at T3 (beat_len = 3) -> T stays 0010 for 4 cycles total; instr_done only on the single unheld 0001 cycle.
- Per-instruction beat_len 0, then 2, then 1 in RUN -> T sequence 1000 | 1000, 0100, 0010 | 1000, 0100; instr_done on 1000, 0010, 0100 respectively. Change beat_len mid-instruction -> no effect.
- Edge cases:
  - instr_cnt preloaded near wrap (CNT_W = 4, 15 completions then one more) -> value 0.
  - rst asserted at T3 -> T = 0000, instr_cnt = 0 next cycle.
  - start and step together -> RUN.
